// File: rtl/l2_reqs_table.sv
// Outstanding-request table for the L2 controller: ready/valid allocation, per-entry state
// updates, registered address lookup with set-conflict detection and a registered forward check.
module l2_reqs_table #(
  parameter int unsigned N_ENTRIES    = 4,
  parameter int unsigned TAG_BITS     = 16,
  parameter int unsigned SET_BITS     = 8,
  parameter int unsigned STATE_BITS   = 4,
  parameter int unsigned PAYLOAD_BITS = 64,
  parameter int unsigned ISD_STATE    = 4,
  parameter int unsigned MIA_STATE    = 6,
  localparam int unsigned IDX_BITS    = $clog2(N_ENTRIES),
  localparam int unsigned CNT_BITS    = $clog2(N_ENTRIES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [TAG_BITS-1:0]     alloc_tag_i,
  input  logic [SET_BITS-1:0]     alloc_set_i,
  input  logic [STATE_BITS-1:0]   alloc_state_i,
  input  logic [PAYLOAD_BITS-1:0] alloc_payload_i,
  output logic [IDX_BITS-1:0]     alloc_idx_o,
  input  logic                    upd_valid_i,
  input  logic [IDX_BITS-1:0]     upd_idx_i,
  input  logic [STATE_BITS-1:0]   upd_state_i,
  input  logic                    lookup_valid_i,
  input  logic [TAG_BITS-1:0]     lookup_tag_i,
  input  logic [SET_BITS-1:0]     lookup_set_i,
  output logic                    lookup_hit_o,
  output logic [IDX_BITS-1:0]     lookup_idx_o,
  output logic                    lookup_conflict_o,
  input  logic                    fwd_valid_i,
  input  logic [TAG_BITS-1:0]     fwd_tag_i,
  input  logic [SET_BITS-1:0]     fwd_set_i,
  input  logic                    fwd_inv_i,
  output logic                    fwd_hit_o,
  output logic [IDX_BITS-1:0]     fwd_idx_o,
  output logic                    fwd_stall_o,
  input  logic [IDX_BITS-1:0]     rd_idx_i,
  output logic [TAG_BITS-1:0]     rd_tag_o,
  output logic [SET_BITS-1:0]     rd_set_o,
  output logic [STATE_BITS-1:0]   rd_state_o,
  output logic [PAYLOAD_BITS-1:0] rd_payload_o,
  output logic [CNT_BITS-1:0]     count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  logic [TAG_BITS-1:0]     tag_q     [N_ENTRIES];
  logic [TAG_BITS-1:0]     tag_d     [N_ENTRIES];
  logic [SET_BITS-1:0]     set_q     [N_ENTRIES];
  logic [SET_BITS-1:0]     set_d     [N_ENTRIES];
  logic [STATE_BITS-1:0]   state_q   [N_ENTRIES];
  logic [STATE_BITS-1:0]   state_d   [N_ENTRIES];
  logic [PAYLOAD_BITS-1:0] payload_q [N_ENTRIES];
  logic [PAYLOAD_BITS-1:0] payload_d [N_ENTRIES];
  logic [CNT_BITS-1:0]     count_q, count_d;

  logic                    lk_hit_q, lk_hit_d, lk_conf_q, lk_conf_d;
  logic [IDX_BITS-1:0]     lk_idx_q, lk_idx_d;
  logic                    fw_hit_q, fw_hit_d, fw_stall_q, fw_stall_d;
  logic [IDX_BITS-1:0]     fw_idx_q, fw_idx_d;
  logic [STATE_BITS-1:0]   fw_state;

  logic alloc_fire, upd_ok;

  // Lowest-index free entry; descending loop lets the lowest index win.
  always_comb begin
    alloc_ready_o = 1'b0;
    alloc_idx_o   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == '0) begin
        alloc_ready_o = 1'b1;
        alloc_idx_o   = IDX_BITS'(i);
      end
    end
  end

  assign alloc_fire = alloc_valid_i && alloc_ready_o && (alloc_state_i != '0);
  // An allocation into the same entry overrides a concurrent update.
  assign upd_ok     = upd_valid_i && (32'(upd_idx_i) < N_ENTRIES) &&
                      !(alloc_fire && (upd_idx_i == alloc_idx_o));

  always_comb begin
    tag_d     = tag_q;
    set_d     = set_q;
    state_d   = state_q;
    payload_d = payload_q;
    if (upd_ok) begin
      state_d[upd_idx_i] = upd_state_i;
    end
    if (alloc_fire) begin
      tag_d[alloc_idx_o]     = alloc_tag_i;
      set_d[alloc_idx_o]     = alloc_set_i;
      state_d[alloc_idx_o]   = alloc_state_i;
      payload_d[alloc_idx_o] = alloc_payload_i;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (state_d[i] != '0) count_d = count_d + CNT_BITS'(1);
    end
  end

  always_comb begin
    lk_hit_d  = 1'b0;
    lk_idx_d  = '0;
    lk_conf_d = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] != '0 && set_q[i] == lookup_set_i) begin
        lk_conf_d = 1'b1;
        if (tag_q[i] == lookup_tag_i) begin
          lk_hit_d = 1'b1;
          lk_idx_d = IDX_BITS'(i);
        end
      end
    end
  end

  always_comb begin
    fw_hit_d = 1'b0;
    fw_idx_d = '0;
    fw_state = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] != '0 && set_q[i] == fwd_set_i && tag_q[i] == fwd_tag_i) begin
        fw_hit_d = 1'b1;
        fw_idx_d = IDX_BITS'(i);
        fw_state = state_q[i];
      end
    end
    if (fwd_inv_i) fw_stall_d = fw_hit_d && (fw_state == STATE_BITS'(ISD_STATE));
    else           fw_stall_d = fw_hit_d && (fw_state != STATE_BITS'(MIA_STATE));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tag_q[i]     <= '0;
        set_q[i]     <= '0;
        state_q[i]   <= '0;
        payload_q[i] <= '0;
      end
      count_q    <= '0;
      lk_hit_q   <= 1'b0;
      lk_idx_q   <= '0;
      lk_conf_q  <= 1'b0;
      fw_hit_q   <= 1'b0;
      fw_idx_q   <= '0;
      fw_stall_q <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      set_q     <= set_d;
      state_q   <= state_d;
      payload_q <= payload_d;
      count_q   <= count_d;
      if (lookup_valid_i) begin
        lk_hit_q  <= lk_hit_d;
        lk_idx_q  <= lk_idx_d;
        lk_conf_q <= lk_conf_d;
      end
      if (fwd_valid_i) begin
        fw_hit_q   <= fw_hit_d;
        fw_idx_q   <= fw_idx_d;
        fw_stall_q <= fw_stall_d;
      end
    end
  end

  assign lookup_hit_o      = lk_hit_q;
  assign lookup_idx_o      = lk_idx_q;
  assign lookup_conflict_o = lk_conf_q;
  assign fwd_hit_o         = fw_hit_q;
  assign fwd_idx_o         = fw_idx_q;
  assign fwd_stall_o       = fw_stall_q;

  assign rd_tag_o     = tag_q[rd_idx_i];
  assign rd_set_o     = set_q[rd_idx_i];
  assign rd_state_o   = state_q[rd_idx_i];
  assign rd_payload_o = payload_q[rd_idx_i];

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_BITS'(N_ENTRIES));
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_l2_reqs_table.sv
// Scoreboard bench for l2_reqs_table: a table-level model predicts lookup/forward results
// and post-edge status; a monitor pops predictions and compares them with the DUT.
module tb_l2_reqs_table;

  localparam int N   = 4;
  localparam int ISD = 4;
  localparam int MIA = 6;

  logic        clk, rst;
  logic        alloc_valid, alloc_ready;
  logic [15:0] alloc_tag;
  logic [7:0]  alloc_set;
  logic [3:0]  alloc_state;
  logic [63:0] alloc_payload;
  logic [1:0]  alloc_idx;
  logic        upd_valid;
  logic [1:0]  upd_idx;
  logic [3:0]  upd_state;
  logic        lookup_valid, lookup_hit, lookup_conflict;
  logic [15:0] lookup_tag;
  logic [7:0]  lookup_set;
  logic [1:0]  lookup_idx;
  logic        fwd_valid, fwd_inv, fwd_hit, fwd_stall;
  logic [15:0] fwd_tag;
  logic [7:0]  fwd_set;
  logic [1:0]  fwd_idx;
  logic [1:0]  rd_idx;
  logic [15:0] rd_tag;
  logic [7:0]  rd_set;
  logic [3:0]  rd_state;
  logic [63:0] rd_payload;
  logic [2:0]  count;
  logic        full, empty;

  l2_reqs_table dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_tag_i(alloc_tag),
    .alloc_set_i(alloc_set), .alloc_state_i(alloc_state), .alloc_payload_i(alloc_payload),
    .alloc_idx_o(alloc_idx),
    .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_state_i(upd_state),
    .lookup_valid_i(lookup_valid), .lookup_tag_i(lookup_tag), .lookup_set_i(lookup_set),
    .lookup_hit_o(lookup_hit), .lookup_idx_o(lookup_idx), .lookup_conflict_o(lookup_conflict),
    .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag), .fwd_set_i(fwd_set), .fwd_inv_i(fwd_inv),
    .fwd_hit_o(fwd_hit), .fwd_idx_o(fwd_idx), .fwd_stall_o(fwd_stall),
    .rd_idx_i(rd_idx), .rd_tag_o(rd_tag), .rd_set_o(rd_set), .rd_state_o(rd_state),
    .rd_payload_o(rd_payload),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic hit; logic [1:0] idx; logic conf; } lk_t;
  typedef struct packed { logic hit; logic [1:0] idx; logic stall; } fw_t;
  typedef struct packed {
    logic [2:0] cnt; logic full; logic empty; logic ready; logic [1:0] aidx;
    logic [3:0] st; logic [15:0] tag; logic [7:0] set; logic [63:0] pay;
  } st_t;

  lk_t lk_q[$];
  fw_t fw_q[$];
  st_t st_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_tag [N];
  logic [7:0]  m_set [N];
  logic [3:0]  m_state [N];
  logic [63:0] m_pay [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tag[i] = '0; m_set[i] = '0; m_state[i] = '0; m_pay[i] = '0;
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (m_state[i] == 0) return i;
    return -1;
  endfunction

  task automatic idle();
    alloc_valid = 0; alloc_tag = '0; alloc_set = '0; alloc_state = '0; alloc_payload = '0;
    upd_valid = 0; upd_idx = '0; upd_state = '0;
    lookup_valid = 0; lookup_tag = '0; lookup_set = '0;
    fwd_valid = 0; fwd_tag = '0; fwd_set = '0; fwd_inv = 0;
  endtask

  // Called at a falling edge with inputs already driven; predicts, then advances one clock.
  task automatic step();
    int  ff, aidx, cnt, hi;
    bit  fire;
    lk_t le;
    fw_t fe;
    st_t se;
    ff   = first_free();
    aidx = (ff < 0) ? 0 : ff;
    fire = alloc_valid && (ff >= 0) && (alloc_state != 0);
    if (lookup_valid) begin
      le = '0;
      for (int i = 0; i < N; i++) begin
        if (m_state[i] != 0 && m_set[i] == lookup_set) begin
          le.conf = 1;
          if (m_tag[i] == lookup_tag && !le.hit) begin le.hit = 1; le.idx = 2'(i); end
        end
      end
      lk_q.push_back(le);
    end
    if (fwd_valid) begin
      fe = '0;
      hi = -1;
      for (int i = 0; i < N; i++)
        if (hi < 0 && m_state[i] != 0 && m_set[i] == fwd_set && m_tag[i] == fwd_tag) hi = i;
      if (hi >= 0) begin
        fe.hit   = 1;
        fe.idx   = 2'(hi);
        fe.stall = fwd_inv ? (m_state[hi] == ISD) : (m_state[hi] != MIA);
      end
      fw_q.push_back(fe);
    end
    if (upd_valid && !(fire && int'(upd_idx) == aidx)) m_state[upd_idx] = upd_state;
    if (fire) begin
      m_tag[aidx] = alloc_tag; m_set[aidx] = alloc_set;
      m_state[aidx] = alloc_state; m_pay[aidx] = alloc_payload;
    end
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_state[i] != 0) cnt++;
    ff       = first_free();
    se.cnt   = 3'(cnt);
    se.full  = (cnt == N);
    se.empty = (cnt == 0);
    se.ready = (ff >= 0);
    se.aidx  = (ff < 0) ? 2'd0 : 2'(ff);
    se.st    = m_state[rd_idx];
    se.tag   = m_tag[rd_idx];
    se.set   = m_set[rd_idx];
    se.pay   = m_pay[rd_idx];
    st_q.push_back(se);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: results of a posedge are compared 1 time unit after it.
  initial begin
    logic lv, fv, r;
    lk_t  le;
    fw_t  fe;
    st_t  se;
    forever begin
      @(posedge clk);
      lv = lookup_valid; fv = fwd_valid; r = rst;
      #1;
      if (!r && !rst) begin
        if (lv) begin
          if (lk_q.size() == 0) chk("lookup_queue_underflow", 1, 0);
          else begin
            le = lk_q.pop_front();
            chk("lookup_hit", lookup_hit, le.hit);
            chk("lookup_idx", lookup_idx, le.idx);
            chk("lookup_conflict", lookup_conflict, le.conf);
          end
        end
        if (fv) begin
          if (fw_q.size() == 0) chk("fwd_queue_underflow", 1, 0);
          else begin
            fe = fw_q.pop_front();
            chk("fwd_hit", fwd_hit, fe.hit);
            chk("fwd_idx", fwd_idx, fe.idx);
            chk("fwd_stall", fwd_stall, fe.stall);
          end
        end
        if (st_q.size() == 0) chk("status_queue_underflow", 1, 0);
        else begin
          se = st_q.pop_front();
          chk("count", count, se.cnt);
          chk("full", full, se.full);
          chk("empty", empty, se.empty);
          chk("alloc_ready", alloc_ready, se.ready);
          chk("alloc_idx", alloc_idx, se.aidx);
          chk("rd_state", rd_state, se.st);
          chk("rd_tag", rd_tag, se.tag);
          chk("rd_set", rd_set, se.set);
          chk("rd_payload", rd_payload, se.pay);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_alloc_ready"}, alloc_ready, 1);
    chk({tag, "_alloc_idx"}, alloc_idx, 0);
    chk({tag, "_lookup"}, {lookup_hit, lookup_idx, lookup_conflict}, 0);
    chk({tag, "_fwd"}, {fwd_hit, fwd_idx, fwd_stall}, 0);
    chk({tag, "_rd"}, {rd_state, rd_tag, rd_set}, 0);
    chk({tag, "_rd_payload"}, rd_payload, 0);
  endtask

  initial begin
    idle();
    rd_idx = '0;
    rst = 1'b1;
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill all four entries, then try a fifth.
    for (int i = 0; i < 4; i++) begin
      idle();
      alloc_valid = 1; alloc_tag = 16'(16'h10 + i); alloc_set = 8'd5; alloc_state = 4'd2;
      alloc_payload = {$urandom, $urandom};
      rd_idx = 2'(i);
      step();
    end
    chk("full_after_fill", full, 1);
    idle();
    alloc_valid = 1; alloc_tag = 16'h55; alloc_set = 8'd5; alloc_state = 4'd3;
    step();
    chk("count_after_fifth", count, 4);

    idle(); lookup_valid = 1; lookup_tag = 16'h12; lookup_set = 8'd5; step();
    chk("lk_0x12", {lookup_hit, lookup_idx, lookup_conflict}, {1'b1, 2'd2, 1'b1});
    idle(); lookup_valid = 1; lookup_tag = 16'h99; lookup_set = 8'd5; step();
    chk("lk_0x99_s5", {lookup_hit, lookup_idx, lookup_conflict}, {1'b0, 2'd0, 1'b1});
    idle(); lookup_valid = 1; lookup_tag = 16'h99; lookup_set = 8'd6; step();
    chk("lk_0x99_s6", lookup_conflict, 0);

    // Free entry 1 while an allocation is attempted at full.
    idle();
    upd_valid = 1; upd_idx = 2'd1; upd_state = 4'd0;
    alloc_valid = 1; alloc_tag = 16'h77; alloc_set = 8'd5; alloc_state = 4'd3;
    step();
    chk("count_after_free", count, 3);
    chk("alloc_idx_after_free", alloc_idx, 1);
    idle(); alloc_valid = 1; alloc_tag = 16'h20; alloc_set = 8'd5; alloc_state = 4'd2;
    alloc_payload = 64'hdead_beef_0000_0020; rd_idx = 2'd1;
    step();
    chk("count_after_realloc", count, 4);

    idle(); upd_valid = 1; upd_idx = 2'd0; upd_state = 4'(ISD); step();
    idle(); upd_valid = 1; upd_idx = 2'd2; upd_state = 4'(MIA); step();
    idle(); fwd_valid = 1; fwd_tag = 16'h10; fwd_set = 8'd5; fwd_inv = 1; step();
    chk("fwd_inv_isd", {fwd_hit, fwd_idx, fwd_stall}, {1'b1, 2'd0, 1'b1});
    idle(); fwd_valid = 1; fwd_tag = 16'h12; fwd_set = 8'd5; fwd_inv = 0;
    lookup_valid = 1; lookup_tag = 16'h13; lookup_set = 8'd5; step();
    chk("fwd_noinv_mia", {fwd_hit, fwd_stall}, {1'b1, 1'b0});
    idle(); fwd_valid = 1; fwd_tag = 16'h12; fwd_set = 8'd5; fwd_inv = 1; step();
    chk("fwd_inv_mia", fwd_stall, 0);

    // Lookup of an entry being allocated sees pre-edge contents.
    idle(); upd_valid = 1; upd_idx = 2'd3; upd_state = 4'd0; step();
    idle();
    alloc_valid = 1; alloc_tag = 16'h30; alloc_set = 8'd7; alloc_state = 4'd1;
    lookup_valid = 1; lookup_tag = 16'h30; lookup_set = 8'd7;
    step();
    chk("lk_same_cycle_alloc", lookup_hit, 0);
    idle(); lookup_valid = 1; lookup_tag = 16'h30; lookup_set = 8'd7; step();
    chk("lk_after_alloc", {lookup_hit, lookup_idx}, {1'b1, 2'd3});

    idle(); upd_valid = 1; upd_idx = 2'd3; upd_state = 4'd0; step();
    chk("count_before_reset", count, 3);

    // Asynchronous reset mid-cycle.
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("alloc_idx_after_release", alloc_idx, 0);

    // Random phase over a small address space so hits and conflicts are frequent.
    for (int c = 0; c < 500; c++) begin
      alloc_valid   = 1'($urandom % 2);
      alloc_tag     = 16'($urandom % 4);
      alloc_set     = 8'($urandom % 2);
      alloc_state   = 4'($urandom % 8);
      alloc_payload = {$urandom, $urandom};
      upd_valid     = ($urandom % 3) == 0;
      upd_idx       = 2'($urandom % 4);
      upd_state     = ($urandom % 2) ? 4'd0 : 4'($urandom % 8);
      lookup_valid  = 1'($urandom % 2);
      lookup_tag    = 16'($urandom % 4);
      lookup_set    = 8'($urandom % 2);
      fwd_valid     = 1'($urandom % 2);
      fwd_tag       = 16'($urandom % 4);
      fwd_set       = 8'($urandom % 2);
      fwd_inv       = 1'($urandom % 2);
      rd_idx        = 2'($urandom % 4);
      step();
    end

    chk("lk_queue_drained", lk_q.size(), 0);
    chk("fw_queue_drained", fw_q.size(), 0);
    chk("st_queue_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
